// File: rtl/sram_bank_ctrl.sv
// Multi-bank asynchronous SRAM controller: bank decode plus a fixed SETUP/ACCESS/RESP pin cycle.
// Define SRAM_CTRL_RDBUF_EN to add a one-entry read buffer that short-circuits repeated reads.
module sram_bank_ctrl #(
  parameter int          NUM_BANKS   = 2,
  parameter int          ADDR_W      = 20,
  parameter int          DATA_W      = 32,
  parameter int          WAIT_CYCLES = 2,
  parameter int          BANK_LSB    = 22,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic                          clk_50M,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [31:0]                   req_addr,
  input  logic [DATA_W/8-1:0]           req_be,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic [NUM_BANKS*ADDR_W-1:0]   ram_addr,
  output logic [NUM_BANKS-1:0]          ram_ce_n,
  output logic [NUM_BANKS-1:0]          ram_oe_n,
  output logic [NUM_BANKS-1:0]          ram_we_n,
  output logic [NUM_BANKS*DATA_W/8-1:0] ram_be_n,
  inout  wire  [NUM_BANKS*DATA_W-1:0]   ram_data
);

  localparam int BE_W   = DATA_W / 8;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [32:0] LIMIT = 33'(NUM_BANKS) << BANK_LSB;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_we;
  logic [BANK_W-1:0]             r_bank;
  logic [DATA_W-1:0]             r_wdata;
  logic [NUM_BANKS-1:0]          r_drive;
  logic                          r_rspValid;
  logic [DATA_W-1:0]             r_rspRdata;
  logic                          r_rspErr;
  logic [NUM_BANKS*ADDR_W-1:0]   r_addr;
  logic [NUM_BANKS-1:0]          r_ceN;
  logic [NUM_BANKS-1:0]          r_oeN;
  logic [NUM_BANKS-1:0]          r_weN;
  logic [NUM_BANKS*BE_W-1:0]     r_beN;

  logic [31:0]                   w_off;
  logic                          w_err;
  logic [BANK_W-1:0]             w_bank;
  logic [ADDR_W-1:0]             w_word;
  logic [DATA_W-1:0]             w_rdBus;

  assign w_off   = req_addr - BASE_ADDR;
  assign w_err   = (req_addr < BASE_ADDR) || ({1'b0, w_off} >= LIMIT);
  assign w_bank  = BANK_W'(w_off >> BANK_LSB);
  assign w_word  = w_off[2 +: ADDR_W];
  assign w_rdBus = ram_data[int'(r_bank)*DATA_W +: DATA_W];

`ifdef SRAM_CTRL_RDBUF_EN
  logic                 r_bufValid;
  logic [BANK_W-1:0]    r_bufBank;
  logic [ADDR_W-1:0]    r_bufWord;
  logic [DATA_W-1:0]    r_bufData;
  logic [ADDR_W-1:0]    r_word;
  logic                 w_bufMatch;

  assign w_bufMatch = r_bufValid && (r_bufBank == w_bank) && (r_bufWord == w_word);

  function automatic logic [DATA_W-1:0] mergeBytes(input logic [DATA_W-1:0] oldD,
                                                   input logic [DATA_W-1:0] newD,
                                                   input logic [BE_W-1:0]   be);
    for (int i = 0; i < BE_W; i++)
      mergeBytes[i*8 +: 8] = be[i] ? newD[i*8 +: 8] : oldD[i*8 +: 8];
  endfunction
`endif

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;
  assign ram_addr  = r_addr;
  assign ram_ce_n  = r_ceN;
  assign ram_oe_n  = r_oeN;
  assign ram_we_n  = r_weN;
  assign ram_be_n  = r_beN;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_dataDrv
    assign ram_data[b*DATA_W +: DATA_W] = r_drive[b] ? r_wdata : {DATA_W{1'bz}};
  end

  // Pins are registered so each state's pin pattern is set on the edge that enters it.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_bank     <= '0;
      r_wdata    <= '0;
      r_drive    <= '0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
      r_addr     <= '0;
      r_ceN      <= '1;
      r_oeN      <= '1;
      r_weN      <= '1;
      r_beN      <= '1;
`ifdef SRAM_CTRL_RDBUF_EN
      r_bufValid <= 1'b0;
      r_bufBank  <= '0;
      r_bufWord  <= '0;
      r_bufData  <= '0;
      r_word     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_err) begin
              r_state    <= ST_RESP;
              r_rspValid <= 1'b1;
              r_rspErr   <= 1'b1;
              r_rspRdata <= '0;
            end
`ifdef SRAM_CTRL_RDBUF_EN
            else if (!req_we && w_bufMatch) begin
              r_state    <= ST_RESP;
              r_rspValid <= 1'b1;
              r_rspRdata <= r_bufData;
            end
`endif
            else begin
              r_state                           <= ST_SETUP;
              r_we                              <= req_we;
              r_bank                            <= w_bank;
              r_wdata                           <= req_wdata;
              r_ceN[w_bank]                     <= 1'b0;
              r_addr[int'(w_bank)*ADDR_W +: ADDR_W] <= w_word;
              if (req_we) begin
                r_beN[int'(w_bank)*BE_W +: BE_W] <= ~req_be;
                r_drive[w_bank]                  <= 1'b1;
              end else begin
                r_beN[int'(w_bank)*BE_W +: BE_W] <= '0;
                r_oeN[w_bank]                    <= 1'b0;
              end
`ifdef SRAM_CTRL_RDBUF_EN
              r_word <= w_word;
              if (req_we && w_bufMatch)
                r_bufData <= mergeBytes(r_bufData, req_wdata, req_be);
`endif
            end
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
          if (r_we)
            r_weN[r_bank] <= 1'b0;
        end
        ST_ACCESS: begin
          if (r_cnt == '0) begin
            r_state    <= ST_RESP;
            r_rspValid <= 1'b1;
            if (r_we) begin
              r_weN[r_bank] <= 1'b1;
              r_rspRdata    <= '0;
            end else begin
              r_oeN[r_bank] <= 1'b1;
              r_rspRdata    <= w_rdBus;
`ifdef SRAM_CTRL_RDBUF_EN
              r_bufValid <= 1'b1;
              r_bufBank  <= r_bank;
              r_bufWord  <= r_word;
              r_bufData  <= w_rdBus;
`endif
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          // Chip enable and write data are held through this cycle for write hold time.
          r_state    <= ST_IDLE;
          r_rspValid <= 1'b0;
          r_rspErr   <= 1'b0;
          r_rspRdata <= '0;
          r_ceN      <= '1;
          r_oeN      <= '1;
          r_weN      <= '1;
          r_beN      <= '1;
          r_drive    <= '0;
          r_addr     <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl with a two-bank behavioural SRAM model.
// Expected latencies follow SRAM_CTRL_RDBUF_EN when it is defined for the build.
module tb_sram_bank_ctrl;

  localparam int NB  = 2;
  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int BEW = 4;

`ifdef SRAM_CTRL_RDBUF_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 4;
`endif

  logic              clk_50M = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [BEW-1:0]    req_be = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [NB*AW-1:0]  ram_addr;
  logic [NB-1:0]     ram_ce_n;
  logic [NB-1:0]     ram_oe_n;
  logic [NB-1:0]     ram_we_n;
  logic [NB*BEW-1:0] ram_be_n;
  wire  [NB*DW-1:0]  ram_data;

  sram_bank_ctrl dut (
    .clk_50M   (clk_50M),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_addr  (ram_addr),
    .ram_ce_n  (ram_ce_n),
    .ram_oe_n  (ram_oe_n),
    .ram_we_n  (ram_we_n),
    .ram_be_n  (ram_be_n),
    .ram_data  (ram_data)
  );

  always #10 clk_50M = ~clk_50M;

  // SRAM model: 256 words per bank, byte writes while ce_n and we_n are low.
  logic [31:0] mem [0:1][0:255];
  logic        preEn = 1'b0;
  logic        preBank = 1'b0;
  logic [7:0]  preWord = '0;
  logic [31:0] preData = '0;

  always @(posedge clk_50M) begin
    if (preEn)
      mem[preBank][preWord] <= preData;
    for (int b = 0; b < NB; b++)
      if (!ram_ce_n[b] && !ram_we_n[b])
        for (int k = 0; k < BEW; k++)
          if (!ram_be_n[b*BEW+k])
            mem[b][ram_addr[b*AW +: 8]][k*8 +: 8] <= ram_data[b*DW + k*8 +: 8];
  end

  assign ram_data[31:0]  = (!ram_ce_n[0] && !ram_oe_n[0]) ? mem[0][ram_addr[7:0]]   : 32'bz;
  assign ram_data[63:32] = (!ram_ce_n[1] && !ram_oe_n[1]) ? mem[1][ram_addr[27:20]] : 32'bz;

  int          testCount = 0;
  int          failCount = 0;
  int          latency;
  int          weLow;
  int          multiCe;
  logic [1:0]  ceSeen;
  logic [31:0] gotData;
  logic        gotErr;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one request for a single clock, then scrambles the request fields.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    @(posedge clk_50M);
    @(negedge clk_50M);
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'h8000_0FFC;
    req_be    = 4'hA;
    req_wdata = 32'hA5A5_5A5A;
  endtask

  task automatic waitResponse();
    latency = 1;
    weLow   = 0;
    multiCe = 0;
    ceSeen  = 2'b00;
    forever begin
      ceSeen = ceSeen | ~ram_ce_n;
      if ($countones(~ram_ce_n) > 1) multiCe++;
      if (ram_we_n != 2'b11) weLow++;
      if (rsp_valid || latency >= 20) break;
      @(negedge clk_50M);
      latency++;
    end
    gotData = rsp_rdata;
    gotErr  = rsp_err;
    checkOutput("rsp_seen", {63'b0, rsp_valid}, 64'd1);
  endtask

  task automatic endResponse(input string tag);
    @(negedge clk_50M);
    checkOutput({tag, "_pulse"}, {63'b0, rsp_valid}, 64'd0);
    checkOutput({tag, "_ready"}, {63'b0, req_ready}, 64'd1);
    checkOutput({tag, "_idle"},  {62'b0, ram_ce_n},  64'h3);
  endtask

  task automatic preload(input logic bank, input logic [7:0] word, input logic [31:0] data);
    preEn   = 1'b1;
    preBank = bank;
    preWord = word;
    preData = data;
    @(negedge clk_50M);
    preEn   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #25;
    checkOutput("rst_ready", {63'b0, req_ready}, 64'd1);
    checkOutput("rst_rvalid", {63'b0, rsp_valid}, 64'd0);
    checkOutput("rst_rdata", {32'b0, rsp_rdata}, 64'd0);
    checkOutput("rst_err", {63'b0, rsp_err}, 64'd0);
    checkOutput("rst_ce", {62'b0, ram_ce_n}, 64'h3);
    checkOutput("rst_oe", {62'b0, ram_oe_n}, 64'h3);
    checkOutput("rst_we", {62'b0, ram_we_n}, 64'h3);
    checkOutput("rst_be", {56'b0, ram_be_n}, 64'hFF);
    checkOutput("rst_addr", {24'b0, ram_addr}, 64'h0);
    @(negedge clk_50M);
    reset_n = 1'b1;
    @(negedge clk_50M);

    // Full-word write to bank 0
    applyStimulus(1'b1, 32'h8000_0100, 4'hF, 32'hDEAD_BEEF);
    checkOutput("wr_setup_ce", {62'b0, ram_ce_n}, 64'h2);
    checkOutput("wr_setup_addr", {44'b0, ram_addr[19:0]}, 64'h40);
    checkOutput("wr_setup_be", {56'b0, ram_be_n}, 64'hF0);
    checkOutput("wr_setup_we", {62'b0, ram_we_n}, 64'h3);
    checkOutput("wr_setup_oe", {62'b0, ram_oe_n}, 64'h3);
    checkOutput("wr_setup_ready", {63'b0, req_ready}, 64'd0);
    waitResponse();
    checkOutput("wr_latency", 64'(latency), 64'd4);
    checkOutput("wr_we_cycles", 64'(weLow), 64'd2);
    checkOutput("wr_banks", {62'b0, ceSeen}, 64'h1);
    checkOutput("wr_rdata", {32'b0, gotData}, 64'h0);
    checkOutput("wr_err", {63'b0, gotErr}, 64'd0);
    checkOutput("wr_resp_ce", {62'b0, ram_ce_n}, 64'h2);
    endResponse("wr");
    checkOutput("wr_mem", {32'b0, mem[0][8'h40]}, 64'hDEAD_BEEF);

    // Read from bank 1 (ExtRAM)
    preload(1'b1, 8'h01, 32'h1234_5678);
    applyStimulus(1'b0, 32'h8040_0004, 4'h0, 32'h0);
    checkOutput("rd_setup_ce", {62'b0, ram_ce_n}, 64'h1);
    checkOutput("rd_setup_addr", {44'b0, ram_addr[39:20]}, 64'h1);
    checkOutput("rd_setup_oe", {62'b0, ram_oe_n}, 64'h1);
    checkOutput("rd_setup_be", {56'b0, ram_be_n}, 64'h0F);
    waitResponse();
    checkOutput("rd_latency", 64'(latency), 64'd4);
    checkOutput("rd_banks", {62'b0, ceSeen}, 64'h2);
    checkOutput("rd_multi", 64'(multiCe), 64'd0);
    checkOutput("rd_data", {32'b0, gotData}, 64'h1234_5678);
    endResponse("rd");

    // Partial byte write then read-back
    preload(1'b0, 8'h50, 32'h1122_3344);
    applyStimulus(1'b1, 32'h8000_0140, 4'b0010, 32'h0000_AB00);
    waitResponse();
    checkOutput("pw_latency", 64'(latency), 64'd4);
    endResponse("pw");
    applyStimulus(1'b0, 32'h8000_0140, 4'h0, 32'h0);
    waitResponse();
    checkOutput("pw_rd_latency", 64'(latency), 64'd4);
    checkOutput("pw_rd_data", {32'b0, gotData}, 64'h1122_AB44);
    endResponse("pw_rd");

    // Write with no byte enables leaves memory unchanged
    applyStimulus(1'b1, 32'h8000_0140, 4'h0, 32'hFFFF_FFFF);
    checkOutput("be0_setup_be", {56'b0, ram_be_n}, 64'hFF);
    waitResponse();
    checkOutput("be0_latency", 64'(latency), 64'd4);
    checkOutput("be0_err", {63'b0, gotErr}, 64'd0);
    endResponse("be0");
    checkOutput("be0_mem", {32'b0, mem[0][8'h50]}, 64'h1122_AB44);
    applyStimulus(1'b0, 32'h8000_0140, 4'h0, 32'h0);
    waitResponse();
    checkOutput("be0_rd_latency", 64'(latency), 64'(HIT_LAT));
    checkOutput("be0_rd_data", {32'b0, gotData}, 64'h1122_AB44);
    endResponse("be0_rd");

    // Out-of-range bank and below-base errors
    applyStimulus(1'b0, 32'h8080_0000, 4'h0, 32'h0);
    checkOutput("err_oe", {62'b0, ram_oe_n}, 64'h3);
    waitResponse();
    checkOutput("err_latency", 64'(latency), 64'd1);
    checkOutput("err_flag", {63'b0, gotErr}, 64'd1);
    checkOutput("err_rdata", {32'b0, gotData}, 64'h0);
    checkOutput("err_banks", {62'b0, ceSeen}, 64'h0);
    endResponse("err");
    applyStimulus(1'b1, 32'h7FFF_FFFC, 4'hF, 32'h1);
    waitResponse();
    checkOutput("low_latency", 64'(latency), 64'd1);
    checkOutput("low_flag", {63'b0, gotErr}, 64'd1);
    endResponse("low");

    // Last word of the last bank is valid
    preload(1'b1, 8'hFF, 32'hCAFE_F00D);
    applyStimulus(1'b0, 32'h807F_FFFC, 4'h0, 32'h0);
    checkOutput("top_addr", {44'b0, ram_addr[39:20]}, 64'hFFFFF);
    waitResponse();
    checkOutput("top_latency", 64'(latency), 64'd4);
    checkOutput("top_err", {63'b0, gotErr}, 64'd0);
    checkOutput("top_data", {32'b0, gotData}, 64'hCAFE_F00D);
    endResponse("top");

    // Reset asserted mid-ACCESS of a write
    applyStimulus(1'b1, 32'h8000_0200, 4'hF, 32'h55AA_55AA);
    @(negedge clk_50M);
    checkOutput("rstmid_access_we", {62'b0, ram_we_n}, 64'h2);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("rstmid_ce", {62'b0, ram_ce_n}, 64'h3);
    checkOutput("rstmid_we", {62'b0, ram_we_n}, 64'h3);
    checkOutput("rstmid_be", {56'b0, ram_be_n}, 64'hFF);
    checkOutput("rstmid_rvalid", {63'b0, rsp_valid}, 64'd0);
    @(negedge clk_50M);
    reset_n = 1'b1;
    @(negedge clk_50M);
    checkOutput("rstmid_ready", {63'b0, req_ready}, 64'd1);

    // Repeated read, then merged write and read-back
    applyStimulus(1'b0, 32'h8040_0004, 4'h0, 32'h0);
    waitResponse();
    checkOutput("rep1_latency", 64'(latency), 64'd4);
    checkOutput("rep1_data", {32'b0, gotData}, 64'h1234_5678);
    endResponse("rep1");
    applyStimulus(1'b0, 32'h8040_0004, 4'h0, 32'h0);
    waitResponse();
    checkOutput("rep2_latency", 64'(latency), 64'(HIT_LAT));
    checkOutput("rep2_data", {32'b0, gotData}, 64'h1234_5678);
    endResponse("rep2");
    applyStimulus(1'b1, 32'h8040_0004, 4'b0001, 32'h0000_00EE);
    waitResponse();
    checkOutput("mrg_wr_latency", 64'(latency), 64'd4);
    endResponse("mrg_wr");
    applyStimulus(1'b0, 32'h8040_0004, 4'h0, 32'h0);
    waitResponse();
    checkOutput("mrg_rd_latency", 64'(latency), 64'(HIT_LAT));
    checkOutput("mrg_rd_data", {32'b0, gotData}, 64'h1234_56EE);
    endResponse("mrg_rd");
    checkOutput("mrg_mem", {32'b0, mem[1][8'h01]}, 64'h1234_56EE);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
